// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter file: event index map and CSR address map.
package perf_pkg;

    localparam int PERF_NUM_EVENTS = 6;
    localparam int PERF_CNT_WIDTH  = 64;

    typedef enum logic [2:0] {
        EV_CYCLE      = 3'd0,
        EV_INSTRET    = 3'd1,
        EV_LOAD_STALL = 3'd2,
        EV_BR_MISPRED = 3'd3,
        EV_IC_MISS    = 3'd4,
        EV_IC_STALL   = 3'd5
    } perf_event_e;

    localparam logic [11:0] PERF_LO_BASE      = 12'hB00;
    localparam logic [11:0] PERF_HI_BASE      = 12'hB80;
    localparam logic [11:0] PERF_INHIBIT_ADDR = 12'h320;

endpackage

// File: rtl/perf_counter.sv
// One 64-bit event counter with independently writable 32-bit halves.
module perf_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    input  logic                 i_lo_we,
    input  logic                 i_hi_we,
    input  logic [31:0]          i_wdata,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // A CSR write in the same cycle as an event overrides it; that increment is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_cnt <= '0;
        else if (i_lo_we) r_cnt[31:0] <= i_wdata;
        else if (i_hi_we) r_cnt[CNT_WIDTH-1:32] <= i_wdata;
        else if (i_inc)   r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-counter file: per-event 64-bit counters, inhibit mask and a CSR port with
// lo->hi snapshot so a lo/hi read pair returns a consistent 64-bit value.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = PERF_NUM_EVENTS,
    parameter int CNT_WIDTH  = PERF_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  csr_req_i,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_rvalid_o,
    output logic                  csr_err_o
);

    localparam int IDX_W = $clog2(NUM_EVENTS);

    logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] w_cnt;
    logic [NUM_EVENTS-1:0]                w_lo_we, w_hi_we, w_inc;
    logic [6:0]                           w_off;
    logic [IDX_W-1:0]                     w_idx;
    logic                                 w_in_rng, w_lo_hit, w_hi_hit, w_inh_hit;
    logic                                 w_rd, w_wr, w_err;
    logic [31:0]                          w_rdata;

    logic [NUM_EVENTS-1:0] r_inhibit;
    logic [31:0]           r_snap;
    logic [IDX_W-1:0]      r_snap_tag;
    logic                  r_snap_vld;
    logic [31:0]           r_rdata;
    logic                  r_rvalid, r_err;

    assign w_off     = csr_addr_i[6:0];
    assign w_idx     = w_off[IDX_W-1:0];
    assign w_in_rng  = (32'(w_off) < NUM_EVENTS);
    assign w_lo_hit  = (csr_addr_i[11:7] == PERF_LO_BASE[11:7]) && w_in_rng;
    assign w_hi_hit  = (csr_addr_i[11:7] == PERF_HI_BASE[11:7]) && w_in_rng;
    assign w_inh_hit = (csr_addr_i == PERF_INHIBIT_ADDR);
    assign w_err     = !(w_lo_hit || w_hi_hit || w_inh_hit);
    assign w_rd      = csr_req_i && !csr_we_i;
    assign w_wr      = csr_req_i && csr_we_i;
    assign w_inc     = event_i & ~r_inhibit;

    always_comb begin
        w_rdata = '0;
        w_lo_we = '0;
        w_hi_we = '0;
        if (w_lo_hit) begin
            w_rdata        = w_cnt[w_idx][31:0];
            w_lo_we[w_idx] = w_wr;
        end else if (w_hi_hit) begin
            // Only reads see the snapshot; writes report the live pre-write half.
            w_rdata        = (w_rd && r_snap_vld && r_snap_tag == w_idx) ? r_snap
                                                                          : w_cnt[w_idx][CNT_WIDTH-1:32];
            w_hi_we[w_idx] = w_wr;
        end else if (w_inh_hit) begin
            w_rdata = 32'(r_inhibit);
        end
    end

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cnt
        perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .i_clk   (clk_i),
            .i_rst_n (reset_ni),
            .i_inc   (w_inc[i]),
            .i_lo_we (w_lo_we[i]),
            .i_hi_we (w_hi_we[i]),
            .i_wdata (csr_wdata_i),
            .o_cnt   (w_cnt[i])
        );
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_inhibit  <= '0;
            r_snap     <= '0;
            r_snap_tag <= '0;
            r_snap_vld <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= csr_req_i;
            if (csr_req_i) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
            end
            if (w_wr && w_inh_hit)
                r_inhibit <= csr_wdata_i[NUM_EVENTS-1:0];
            if (w_rd && w_lo_hit) begin
                r_snap     <= w_cnt[w_idx][CNT_WIDTH-1:32];
                r_snap_tag <= w_idx;
                r_snap_vld <= 1'b1;
            end else if (w_rd && w_hi_hit) begin
                r_snap_vld <= 1'b0;
            end else if (w_wr && (w_lo_hit || w_hi_hit) && r_snap_tag == w_idx) begin
                r_snap_vld <= 1'b0;
            end
        end
    end

    assign csr_rdata_o  = r_rdata;
    assign csr_rvalid_o = r_rvalid;
    assign csr_err_o    = r_err;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench: each request pushes its expected response; a negedge monitor pops and compares.
module tb_perf_counter_unit;

    localparam logic [5:0] EB = 6'b000001;  // cycle event always on

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [5:0]  event_i = '0;
    logic        csr_req_i = 1'b0, csr_we_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_rvalid_o, csr_err_o;

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t        exp_q[$];
    int          vecs = 0;
    int          errs = 0;
    int unsigned ncyc = 0;

    perf_counter_unit dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .event_i      (event_i),
        .csr_req_i    (csr_req_i),
        .csr_we_i     (csr_we_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_rvalid_o (csr_rvalid_o),
        .csr_err_o    (csr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_ni && csr_rvalid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                rsp_t r;
                r = exp_q.pop_front();
                chk({r.tag, "_rdata"}, 64'(csr_rdata_o), 64'(r.d));
                chk({r.tag, "_err"}, 64'(csr_err_o), 64'(r.e));
            end
        end
    end

    task automatic cyc(input logic [5:0] ev, input logic req, input logic we, input logic [11:0] addr,
                       input logic [31:0] wd, input string tag, input logic [31:0] ed, input logic ee);
        @(negedge clk_i);
        event_i     = ev;
        csr_req_i   = req;
        csr_we_i    = we;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
        if (req) exp_q.push_back('{tag, ed, ee});
        @(posedge clk_i);
        if (ev[0]) ncyc++;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] ed,
                      input logic ee = 1'b0, input logic [5:0] ev = EB);
        cyc(ev, 1'b1, 1'b0, addr, 32'h0, tag, ed, ee);
    endtask

    task automatic wr(input string tag, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [31:0] old, input logic [5:0] ev = EB, input logic ee = 1'b0);
        cyc(ev, 1'b1, 1'b1, addr, wd, tag, old, ee);
    endtask

    task automatic idle(input int n = 1, input logic [5:0] ev = EB);
        for (int k = 0; k < n; k++) cyc(ev, 1'b0, 1'b0, 12'h0, 32'h0, "", 32'h0, 1'b0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_rvalid", 64'(csr_rvalid_o), 64'd0);
        chk("rst_rdata", 64'(csr_rdata_o), 64'd0);
        chk("rst_err", 64'(csr_err_o), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        ncyc = 0;

        // 1: quiet read
        rd("t1_b00", 12'hB00, 32'h0, 1'b0, 6'b0);
        rd("t1_inh", 12'h320, 32'h0);

        // 2: instret x10, cycle free-runs
        idle(10, 6'b000011);
        rd("t2_lo1", 12'hB01, 32'd10);
        rd("t2_hi1", 12'hB81, 32'd0);
        rd("t2_lo2", 12'hB02, 32'd0);
        rd("t2_cyc", 12'hB00, ncyc);
        rd("t2_cychi", 12'hB80, 32'd0);

        // 3: 64-bit wrap and lo->hi carry
        wr("t3_wlo", 12'hB02, 32'hFFFF_FFFF, 32'h0);
        wr("t3_whi", 12'hB82, 32'hFFFF_FFFF, 32'h0);
        idle(1, 6'b000101);
        rd("t3_wraplo", 12'hB02, 32'h0);
        rd("t3_wraphi", 12'hB82, 32'h0);
        wr("t3_wlo2", 12'hB02, 32'hFFFF_FFFF, 32'h0);
        wr("t3_whi2", 12'hB82, 32'h0, 32'h0);
        idle(1, 6'b000101);
        rd("t3_carryhi", 12'hB82, 32'd1);
        rd("t3_carrylo", 12'hB02, 32'd0);

        // 4: inhibit; the write cycle itself still counts, the clearing cycle does not
        wr("t4_inh_on", 12'h320, 32'h10, 32'h0, 6'b010001);
        idle(5, 6'b010001);
        rd("t4_frozen", 12'hB04, 32'd1);
        rd("t4_inh_rd", 12'h320, 32'h10);
        wr("t4_inh_off", 12'h320, 32'h0, 32'h10, 6'b010001);
        idle(1, 6'b010001);
        rd("t4_resume", 12'hB04, 32'd2);
        wr("t4_inh_hi", 12'h320, 32'hFFFF_FFC0, 32'h0);
        rd("t4_inh_mask", 12'h320, 32'h0);

        // 5: snapshot consistency on counter 3
        wr("t5_whi", 12'hB83, 32'h0, 32'h0);
        wr("t5_wlo", 12'hB03, 32'hFFFF_FFFF, 32'h0, 6'b001001);
        rd("t5_lo", 12'hB03, 32'hFFFF_FFFF, 1'b0, 6'b001001);
        idle(1, 6'b001001);
        rd("t5_snaphi", 12'hB83, 32'd0, 1'b0, 6'b001001);
        rd("t5_livehi", 12'hB83, 32'd1, 1'b0, 6'b001001);
        rd("t5_lo2", 12'hB03, 32'd3, 1'b0, 6'b001001);
        wr("t5_whi2", 12'hB83, 32'd5, 32'd1);
        rd("t5_inval", 12'hB83, 32'd5);

        // 6: write beats event, unmapped addresses, output hold
        wr("t6_w5", 12'hB05, 32'h1234, 32'h0, 6'b100001);
        rd("t6_r5", 12'hB05, 32'h1234);
        idle(1);
        #1;
        chk("t6_hold_rvalid", 64'(csr_rvalid_o), 64'd0);
        chk("t6_hold_rdata", 64'(csr_rdata_o), 64'h1234);
        wr("t6_wbad", 12'hB06, 32'h1, 32'h0, EB, 1'b1);
        rd("t6_r7ff", 12'h7FF, 32'h0, 1'b1);
        idle(1);
        #1;
        chk("t6_hold_err", 64'(csr_err_o), 64'd1);
        rd("t6_r5b", 12'hB05, 32'h1234);
        idle(2);

        // reset during a pending read
        @(negedge clk_i);
        event_i    = '0;
        csr_req_i  = 1'b1;
        csr_we_i   = 1'b0;
        csr_addr_i = 12'hB05;
        #2 reset_ni = 1'b0;
        @(posedge clk_i);
        #1;
        chk("mid_rst_rvalid", 64'(csr_rvalid_o), 64'd0);
        chk("mid_rst_err", 64'(csr_err_o), 64'd0);
        @(negedge clk_i);
        csr_req_i = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        ncyc = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            chk("post_rst_rvalid", 64'(csr_rvalid_o), 64'd0);
        end
        rd("post_rst_c5", 12'hB05, 32'h0, 1'b0, 6'b0);
        idle(4);
        rd("post_rst_cyc", 12'hB00, ncyc);
        idle(3);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
